// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single busy/settle memory port.
// Define MEM_ARBITER_TIMEOUT_EN to build in the ISSUE/WAIT watchdog that ends a stalled access with err_o.
module mem_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter int SETTLE_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [1:0]              req_i,
  input  logic [1:0]              we_i,
  input  logic [2*ADDR_WIDTH-1:0] addr_i,
  input  logic [2*DATA_WIDTH-1:0] wdata_i,
  output logic [1:0]              gnt_o,
  output logic [1:0]              done_o,
  output logic [1:0]              err_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    mem_wr_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_data_o,
  input  logic                    mem_busy_i,
  input  logic [DATA_WIDTH-1:0]   mem_data_i
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic                    rr_q, rr_d;       // 1: B is favoured on a tie
  logic                    win_q, win_d;     // 1: B owns the transaction
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              gnt_q, gnt_d;
  logic [1:0]              done_q, done_d;
  logic [1:0]              err_q, err_d;
  logic                    mem_wr_q, mem_wr_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    pick_b_s;
  logic                    tmo_s;
  logic [1:0]              win_oh_s;

`ifdef MEM_ARBITER_TIMEOUT_EN
  logic [15:0]             wdog_q, wdog_d;

  // Watchdog counts every cycle spent in ISSUE or WAIT and restarts elsewhere.
  always_comb begin
    wdog_d = 16'd0;
    if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
      wdog_d = wdog_q + 16'd1;
    end else begin
      wdog_d = 16'd0;
    end
    tmo_s = (wdog_q == 16'(TIMEOUT_CYCLES));
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wdog_q <= 16'd0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic unused_tmo_s;
  assign unused_tmo_s = ^16'(TIMEOUT_CYCLES);
  assign tmo_s        = 1'b0;
`endif

  assign pick_b_s = req_i[1] & (~req_i[0] | rr_q);
  assign win_oh_s = win_q ? 2'b10 : 2'b01;

  // Next-state, request latching and registered-output decode.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    err_d   = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (req_i != 2'b00) begin
          state_d = S_ISSUE;
          win_d   = pick_b_s;
          rr_d    = ~pick_b_s;
          we_d    = pick_b_s ? we_i[1] : we_i[0];
          addr_d  = pick_b_s ? addr_i[2*ADDR_WIDTH-1 -: ADDR_WIDTH] : addr_i[ADDR_WIDTH-1:0];
          wdata_d = pick_b_s ? wdata_i[2*DATA_WIDTH-1 -: DATA_WIDTH] : wdata_i[DATA_WIDTH-1:0];
          gnt_d   = pick_b_s ? 2'b10 : 2'b01;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (tmo_s) begin
          state_d = S_DONE;
          err_d   = win_oh_s;
        end else if (mem_busy_i) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (tmo_s) begin
          state_d = S_DONE;
          err_d   = win_oh_s;
        end else if (!mem_busy_i) begin
          state_d = S_SETTLE;
          cnt_d   = 8'(SETTLE_CYCLES);
        end else begin
          state_d = S_WAIT;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_DONE;
          done_d  = win_oh_s;
          if (!we_q) begin
            rdata_d = mem_data_i;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    mem_wr_d = ((state_d == S_ISSUE) || (state_d == S_WAIT)) ? we_d : 1'b0;
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      rr_q     <= 1'b0;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= 8'd0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      mem_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mem_wr_q <= mem_wr_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rdata_o    = rdata_q;
  assign mem_wr_o   = mem_wr_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions plus
// hand-written sequences for tie-breaking, back-to-back, mid-transaction reset and watchdog.
module tb_mem_arbiter;
  localparam int S = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [19:0] addr_i;
  logic [31:0] wdata_i;
  logic [1:0]  gnt_o;
  logic [1:0]  done_o;
  logic [1:0]  err_o;
  logic [15:0] rdata_o;
  logic        mem_wr_o;
  logic [9:0]  mem_addr_o;
  logic [15:0] mem_data_o;
  logic        mem_busy_i;
  logic [15:0] mem_data_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mem_arbiter #(
    .DATA_WIDTH(16), .ADDR_WIDTH(10), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_busy_i(mem_busy_i), .mem_data_i(mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [9:0]  addr_a;
    logic [9:0]  addr_b;
    logic [15:0] wd_a;
    logic [15:0] wd_b;
    int          d;
    int          len;
    logic [15:0] mdata;
    logic [1:0]  exp_win;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One transaction: busy rises d cycles after gnt and stays high for len cycles.
  task automatic run_txn(input logic [1:0] req, input logic [1:0] we,
                         input logic [9:0] addr_a, input logic [9:0] addr_b,
                         input logic [15:0] wd_a, input logic [15:0] wd_b,
                         input int d, input int len, input logic [15:0] mdata,
                         input logic [1:0] exp_win, input logic [15:0] exp_rdata,
                         input bit keep, output int gc, output int dc);
    int k;
    bit wr_ok;
    bit one_gnt;
    logic sel_we;
    logic [9:0] exp_addr;
    logic [15:0] exp_wd;
    sel_we   = exp_win[1] ? we[1] : we[0];
    exp_addr = exp_win[1] ? addr_b : addr_a;
    exp_wd   = exp_win[1] ? wd_b : wd_a;
    req_i = req; we_i = we; addr_i = {addr_b, addr_a}; wdata_i = {wd_b, wd_a};
    mem_busy_i = 1'b0; mem_data_i = mdata;
    k = 0;
    do begin step(); k++; end while (gnt_o == 2'b00 && k < 20);
    gc = cyc;
    chk("gnt", {30'd0, gnt_o}, {30'd0, exp_win});
    chk("mem_addr", {22'd0, mem_addr_o}, {22'd0, exp_addr});
    chk("mem_data", {16'd0, mem_data_o}, {16'd0, exp_wd});
    if (!keep) req_i = req & ~gnt_o;
    wr_ok = 1'b1; one_gnt = 1'b1; k = 0;
    while (k < 80) begin
      mem_busy_i = (k >= d) && (k < d + len);
      if (mem_wr_o !== ((k <= d + len) ? sel_we : 1'b0)) wr_ok = 1'b0;
      step(); k++;
      if (gnt_o != 2'b00) one_gnt = 1'b0;
      if (done_o != 2'b00 || err_o != 2'b00) break;
    end
    dc = cyc;
    mem_busy_i = 1'b0;
    chk("done", {30'd0, done_o}, {30'd0, exp_win});
    chk("err", {30'd0, err_o}, 32'd0);
    chk("latency", k, d + len + S + 2);
    chk("rdata", {16'd0, rdata_o}, {16'd0, exp_rdata});
    chk("mem_wr_seq", {31'd0, wr_ok}, 32'd1);
    chk("mem_wr_done", {31'd0, mem_wr_o}, 32'd0);
    chk("gnt_pulse", {31'd0, one_gnt}, 32'd1);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; req_i = 2'b00; mem_busy_i = 1'b0;
    step(); step();
    rst_ni = 1'b1;
  endtask

  initial begin
    int gc, dc, prev_dc, k;
    bit quiet;
    logic [1:0] exp_order[3];
    vecs[0] = '{2'b01, 2'b01, 10'h005, 10'h000, 16'h1234, 16'h0000, 2, 10, 16'hDEAD, 2'b01, 16'h0000};
    vecs[1] = '{2'b10, 2'b00, 10'h000, 10'h3FF, 16'h0000, 16'h0000, 1, 3,  16'hBEEF, 2'b10, 16'hBEEF};
    vecs[2] = '{2'b01, 2'b00, 10'h0AA, 10'h000, 16'h0000, 16'h0000, 0, 1,  16'h5A5A, 2'b01, 16'h5A5A};
    vecs[3] = '{2'b10, 2'b10, 10'h000, 10'h100, 16'h0000, 16'hCAFE, 0, 2,  16'h1111, 2'b10, 16'h5A5A};
    vecs[4] = '{2'b11, 2'b00, 10'h001, 10'h2F0, 16'h0A0A, 16'h0B0B, 1, 1,  16'h7777, 2'b01, 16'h7777};
    vecs[5] = '{2'b11, 2'b00, 10'h001, 10'h2F0, 16'h0A0A, 16'h0B0B, 3, 2,  16'h8888, 2'b10, 16'h8888};
    vecs[6] = '{2'b10, 2'b00, 10'h000, 10'h044, 16'h0000, 16'h0000, 0, 4,  16'h9999, 2'b10, 16'h9999};

    req_i = 2'b00; we_i = 2'b00; addr_i = 20'd0; wdata_i = 32'd0;
    mem_busy_i = 1'b0; mem_data_i = 16'd0; rst_ni = 1'b0;
    step(); step();
    chk("rst_gnt", {30'd0, gnt_o}, 32'd0);
    chk("rst_done", {30'd0, done_o}, 32'd0);
    chk("rst_err", {30'd0, err_o}, 32'd0);
    chk("rst_rdata", {16'd0, rdata_o}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr_o}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr_o}, 32'd0);
    chk("rst_mem_data", {16'd0, mem_data_o}, 32'd0);
    rst_ni = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].req, vecs[i].we, vecs[i].addr_a, vecs[i].addr_b, vecs[i].wd_a,
              vecs[i].wd_b, vecs[i].d, vecs[i].len, vecs[i].mdata, vecs[i].exp_win,
              vecs[i].exp_rdata, 1'b0, gc, dc);
    end

    // Both requesters held high from reset: grants alternate A, B, A.
    do_reset();
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      run_txn(2'b11, 2'b00, 10'h010, 10'h020, 16'h0000, 16'h0000, 0, 1,
              16'h4000 + 16'(i), exp_order[i], 16'h4000 + 16'(i), 1'b1, gc, dc);
    end

    // A alone, request held continuously: one idle cycle between done and next gnt.
    prev_dc = dc;
    for (int i = 0; i < 3; i++) begin
      run_txn(2'b01, 2'b01, 10'h030 + 10'(i), 10'h000, 16'h6000 + 16'(i), 16'h0000, 1, 2,
              16'h0000, 2'b01, 16'h4002, 1'b1, gc, dc);
      chk("b2b_gap", gc - prev_dc, 32'd2);
      prev_dc = dc;
    end

    // Reset during WAIT of a write by A.
    req_i = 2'b01; we_i = 2'b01; addr_i = {10'h000, 10'h012}; wdata_i = {16'h0000, 16'hABCD};
    k = 0;
    do begin step(); k++; end while (gnt_o == 2'b00 && k < 20);
    chk("rstmid_gnt", {30'd0, gnt_o}, 32'd1);
    req_i = 2'b00; mem_busy_i = 1'b1;
    step(); step();
    chk("rstmid_wr_before", {31'd0, mem_wr_o}, 32'd1);
    rst_ni = 1'b0;
    step();
    chk("rstmid_wr", {31'd0, mem_wr_o}, 32'd0);
    chk("rstmid_done", {30'd0, done_o}, 32'd0);
    chk("rstmid_err", {30'd0, err_o}, 32'd0);
    chk("rstmid_addr", {22'd0, mem_addr_o}, 32'd0);
    rst_ni = 1'b1; mem_busy_i = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done_o != 2'b00 || err_o != 2'b00 || gnt_o != 2'b00) quiet = 1'b0;
    end
    chk("rstmid_quiet", {31'd0, quiet}, 32'd1);
    run_txn(2'b11, 2'b00, 10'h050, 10'h060, 16'h0000, 16'h0000, 0, 1, 16'h2468,
            2'b01, 16'h2468, 1'b0, gc, dc);

`ifdef MEM_ARBITER_TIMEOUT_EN
    // Watchdog: busy never rises, err_o[B] 21 cycles after gnt, then back to IDLE.
    req_i = 2'b10; we_i = 2'b00; addr_i = {10'h077, 10'h000}; mem_busy_i = 1'b0;
    k = 0;
    do begin step(); k++; end while (gnt_o == 2'b00 && k < 20);
    chk("tmo_gnt", {30'd0, gnt_o}, 32'd2);
    req_i = 2'b00; quiet = 1'b1; k = 0;
    while (k < 60) begin
      step(); k++;
      if (done_o != 2'b00) quiet = 1'b0;
      if (err_o != 2'b00) break;
    end
    chk("tmo_err", {30'd0, err_o}, 32'd2);
    chk("tmo_cycle", k, 32'd21);
    chk("tmo_no_done", {31'd0, quiet}, 32'd1);
    chk("tmo_rdata", {16'd0, rdata_o}, 32'h2468);
    run_txn(2'b01, 2'b00, 10'h078, 10'h000, 16'h0000, 16'h0000, 0, 1, 16'h1357,
            2'b01, 16'h1357, 1'b0, gc, dc);
`else
    // No watchdog: a never-busy access stays in ISSUE with no completion.
    req_i = 2'b10; we_i = 2'b10; addr_i = {10'h077, 10'h000}; mem_busy_i = 1'b0;
    k = 0;
    do begin step(); k++; end while (gnt_o == 2'b00 && k < 20);
    chk("stall_gnt", {30'd0, gnt_o}, 32'd2);
    req_i = 2'b00; quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done_o != 2'b00 || err_o != 2'b00 || mem_wr_o != 1'b1) quiet = 1'b0;
    end
    chk("stall_hold", {31'd0, quiet}, 32'd1);
    do_reset();
    step();
    chk("stall_rst_wr", {31'd0, mem_wr_o}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
